// File: rtl/snd_dma_seq_if.sv
// DMA bus slot interface for the sound DMA sequencer.
//   slot     : bus slot strobe, one clk wide, offered to the sequencer
//   sload_n  : active-low load strobe, one clk per granted word
//   sload_ch : granted channel index (zero-extended), held between strobes
//   dma_addr : word address of the granted fetch, held between strobes
// master = bus side, slave = sequencer side.
interface snd_dma_seq_if #(
  parameter int AW = 22
);
  logic          slot;
  logic          sload_n;
  logic [2:0]    sload_ch;
  logic [AW-1:0] dma_addr;

  modport master (output slot, input sload_n, sload_ch, dma_addr);
  modport slave  (input slot, output sload_n, sload_ch, dma_addr);
endinterface

// File: rtl/snd_dma_seq.sv
// Sound DMA sequencer: NCH channels each walking a frame [start, end) of word
// addresses, arbitrated round-robin onto a shared DMA bus slot.
// Ports:
//   clk, porb        : clock, asynchronous active-low reset
//   bus (slave)      : slot in; sload_n / sload_ch / dma_addr out
//   ch_en, ch_rep    : per-channel play enable / repeat mode
//   ch_start, ch_end : per-channel frame bounds, AW bits each, end exclusive
//   ch_sreq          : per-channel FIFO data request
//   irq_mask, irq_ack: interrupt enable / write-one-to-clear of irq_pend
//   sframe, stoff    : channel running / non-repeat frame finished pulse
//   irq_pend, sint   : frame-end pending flags / masked OR of them

// One channel: IDLE/RUN state, word counter and latched frame end.
// The frame start is not kept separately: reload always resamples ch_start,
// so a latched copy would never be observed.
module snd_dma_ch #(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          porb,
  input  logic          en,
  input  logic          rep,
  input  logic          sreq,
  input  logic          gnt,
  input  logic [AW-1:0] start,
  input  logic [AW-1:0] stop,
  output logic          run,
  output logic          elig,
  output logic          fend,
  output logic          stoff,
  output logic [AW-1:0] cnt
);
  typedef enum logic {IDLE, RUN} st_t;

  st_t           st, st_nxt;
  logic [AW-1:0] ereg, ereg_nxt, cnt_nxt;
  logic          hold, hold_nxt;   // blocks restart until en has been low
  logic          stoff_nxt;

  always_ff @(posedge clk or negedge porb) begin
    if (!porb) begin
      st    <= IDLE;
      cnt   <= '0;
      ereg  <= '0;
      hold  <= 1'b0;
      stoff <= 1'b0;
    end else begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      ereg  <= ereg_nxt;
      hold  <= hold_nxt;
      stoff <= stoff_nxt;
    end
  end

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    ereg_nxt  = ereg;
    hold_nxt  = hold;
    stoff_nxt = 1'b0;
    fend      = 1'b0;
    if (!en) begin
      // disable wins over everything, silently
      st_nxt   = IDLE;
      hold_nxt = 1'b0;
    end else if (st == IDLE) begin
      if (!hold) begin
        st_nxt   = RUN;
        cnt_nxt  = start;
        ereg_nxt = stop;
      end
    end else if (cnt == ereg) begin
      // frame end takes this whole cycle; elig is low so no grant collides
      fend = 1'b1;
      if (rep) begin
        cnt_nxt  = start;
        ereg_nxt = stop;
      end else begin
        st_nxt    = IDLE;
        hold_nxt  = 1'b1;
        stoff_nxt = 1'b1;
      end
    end else if (gnt) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  assign run  = (st == RUN);
  assign elig = (st == RUN) && sreq && en && (cnt != ereg);
endmodule

module snd_dma_seq #(
  parameter int NCH = 2,
  parameter int AW  = 22
) (
  input  logic              clk,
  input  logic              porb,
  snd_dma_seq_if.slave      bus,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    ch_rep,
  input  logic [NCH*AW-1:0] ch_start,
  input  logic [NCH*AW-1:0] ch_end,
  input  logic [NCH-1:0]    ch_sreq,
  input  logic [NCH-1:0]    irq_mask,
  input  logic [NCH-1:0]    irq_ack,
  output logic [NCH-1:0]    sframe,
  output logic [NCH-1:0]    stoff,
  output logic [NCH-1:0]    irq_pend,
  output logic              sint
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [2:0]    ch;
    logic [AW-1:0] addr;
  } gnt_t;

  logic [NCH-1:0]         elig, gnt, fend;
  logic [NCH-1:0][AW-1:0] cnt;
  logic [2:0]             ptr;       // first channel the next search tries
  logic [2:0]             gidx;
  logic                   gany;
  logic [AW-1:0]          gaddr;
  logic [STAGES:0]        vld_pipe;
  gnt_t                   g_reg, out_reg;

  snd_dma_ch #(.AW(AW)) u_ch [NCH-1:0] (
    .clk   (clk),
    .porb  (porb),
    .en    (ch_en),
    .rep   (ch_rep),
    .sreq  (ch_sreq),
    .gnt   (gnt),
    .start (ch_start),
    .stop  (ch_end),
    .run   (sframe),
    .elig  (elig),
    .fend  (fend),
    .stoff (stoff),
    .cnt   (cnt)
  );

  // round-robin pick; only the slot strobe can produce a grant
  always_comb begin
    gany = 1'b0;
    gidx = '0;
    if (bus.slot) begin
      for (int k = 0; k < NCH; k++) begin
        if (!gany && elig[(int'(ptr) + k) % NCH]) begin
          gany = 1'b1;
          gidx = 3'((int'(ptr) + k) % NCH);
        end
      end
    end
  end

  always_comb begin
    gnt   = '0;
    gaddr = '0;
    for (int i = 0; i < NCH; i++) begin
      gnt[i] = gany && (gidx == 3'(i));
      if (gnt[i]) gaddr = cnt[i];
    end
  end

  // grant captured at the slot edge, presented as a strobe one edge later
  always_ff @(posedge clk or negedge porb) begin
    if (!porb) begin
      ptr      <= '0;
      vld_pipe <= '0;
      g_reg    <= '0;
      out_reg  <= '0;
      irq_pend <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], gany};
      if (gany) begin
        ptr        <= (gidx == 3'(NCH-1)) ? 3'd0 : gidx + 3'd1;
        g_reg.ch   <= gidx;
        g_reg.addr <= gaddr;
      end
      if (vld_pipe[0]) out_reg <= g_reg;
      irq_pend <= (irq_pend & ~irq_ack) | fend;   // set beats ack
    end
  end

  assign bus.sload_n  = ~vld_pipe[STAGES];
  assign bus.sload_ch = out_reg.ch;
  assign bus.dma_addr = out_reg.addr;
  assign sint         = |(irq_pend & irq_mask);
endmodule

// File: tb/tb_snd_dma_seq.sv
module tb_snd_dma_seq;
  localparam int NCH = 2;
  localparam int AW  = 22;

  logic clk = 1'b0;
  logic porb = 1'b0;
  always #5 clk = ~clk;

  snd_dma_seq_if #(.AW(AW)) bus();
  logic [NCH-1:0]    ch_en, ch_rep, ch_sreq, irq_mask, irq_ack;
  logic [NCH*AW-1:0] ch_start, ch_end;
  logic [NCH-1:0]    sframe, stoff, irq_pend;
  logic              sint;

  snd_dma_seq #(.NCH(NCH), .AW(AW)) dut (
    .clk(clk), .porb(porb), .bus(bus.slave),
    .ch_en(ch_en), .ch_rep(ch_rep), .ch_start(ch_start), .ch_end(ch_end),
    .ch_sreq(ch_sreq), .irq_mask(irq_mask), .irq_ack(irq_ack),
    .sframe(sframe), .stoff(stoff), .irq_pend(irq_pend), .sint(sint)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            due;
    int            ch;
    logic [AW-1:0] addr;
  } exp_t;

  bit            m_run [NCH];
  bit            m_hold[NCH];
  logic [AW-1:0] m_cnt [NCH];
  logic [AW-1:0] m_ereg[NCH];
  logic [NCH-1:0] m_irq, m_stoff;
  int            m_ptr;
  exp_t          mq[$];
  int            cyc = 0;
  bit            exp_sv;
  int            exp_ch;
  logic [AW-1:0] exp_addr;
  logic [NCH-1:0] exp_frame;

  // observed strobes and stoff pulses for the literal checks
  int            log_ch[$];
  logic [AW-1:0] log_addr[$];
  int            stoff_n[NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_hold[i] = 0; m_cnt[i] = '0; m_ereg[i] = '0;
    end
    m_irq = '0; m_stoff = '0; m_ptr = 0;
    mq.delete();
    exp_ch = 0; exp_addr = '0;
  endtask

  // what the next edge must do, from the inputs now applied
  task automatic model_step();
    bit            eg[NCH];
    int            g;
    logic [NCH-1:0] set, so;
    logic [AW-1:0] a, e;
    g = -1;
    for (int i = 0; i < NCH; i++)
      eg[i] = m_run[i] && ch_sreq[i] && ch_en[i] && (m_cnt[i] != m_ereg[i]);
    if (bus.slot)
      for (int k = 0; k < NCH; k++)
        if (g < 0 && eg[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
    if (g >= 0) begin
      mq.push_back('{due: cyc + 2, ch: g, addr: m_cnt[g]});
      m_ptr = (g + 1) % NCH;
    end
    set = '0; so = '0;
    for (int i = 0; i < NCH; i++) begin
      a = ch_start[i*AW +: AW];
      e = ch_end[i*AW +: AW];
      if (!ch_en[i]) begin
        m_run[i] = 0; m_hold[i] = 0;
      end else if (!m_run[i]) begin
        if (!m_hold[i]) begin m_run[i] = 1; m_cnt[i] = a; m_ereg[i] = e; end
      end else if (m_cnt[i] == m_ereg[i]) begin
        set[i] = 1'b1;
        if (ch_rep[i]) begin m_cnt[i] = a; m_ereg[i] = e; end
        else begin m_run[i] = 0; m_hold[i] = 1; so[i] = 1'b1; end
      end else if (g == i) begin
        m_cnt[i] = m_cnt[i] + 1'b1;
      end
    end
    m_irq   = (m_irq & ~irq_ack) | set;
    m_stoff = so;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    cyc++;
    if (!porb) model_reset();
    exp_sv = 0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      exp_sv = 1; exp_ch = mq[0].ch; exp_addr = mq[0].addr;
      void'(mq.pop_front());
    end
    for (int i = 0; i < NCH; i++) exp_frame[i] = m_run[i];
    chk("sload_n",  32'(bus.sload_n),  32'(!exp_sv));
    chk("sload_ch", 32'(bus.sload_ch), 32'(exp_ch));
    chk("dma_addr", 32'(bus.dma_addr), 32'(exp_addr));
    chk("sframe",   32'(sframe),       32'(exp_frame));
    chk("stoff",    32'(stoff),        32'(m_stoff));
    chk("irq_pend", 32'(irq_pend),     32'(m_irq));
    chk("sint",     32'(sint),         32'(|(m_irq & irq_mask)));
    if (bus.sload_n === 1'b0) begin
      log_ch.push_back(int'(bus.sload_ch));
      log_addr.push_back(bus.dma_addr);
    end
    for (int i = 0; i < NCH; i++) if (stoff[i] === 1'b1) stoff_n[i]++;
    if (porb) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic slots(input int n, input int gap);
    repeat (n) begin
      bus.slot = 1'b1; tick(1);
      bus.slot = 1'b0; tick(gap - 1);
    end
  endtask

  task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [AW-1:0] e,
                        input logic rep, input logic sreq);
    ch_start[i*AW +: AW] = a;
    ch_end[i*AW +: AW]   = e;
    ch_rep[i]  = rep;
    ch_sreq[i] = sreq;
  endtask

  task automatic clr_log();
    log_ch.delete();
    log_addr.delete();
    for (int i = 0; i < NCH; i++) stoff_n[i] = 0;
  endtask

  task automatic do_reset();
    porb = 1'b0;
    bus.slot = 1'b0;
    ch_en = '0; ch_rep = '0; ch_sreq = '0; irq_ack = '0; irq_mask = '1;
    ch_start = '0; ch_end = '0;
    tick(2);
    porb = 1'b1;
    clr_log();
  endtask

  initial begin
    do_reset();
    chk("rst_sload_n", 32'(bus.sload_n), 32'd1);
    chk("rst_irq", 32'(irq_pend), 32'd0);

    // single channel, non-repeat
    set_ch(0, 22'h100, 22'h103, 1'b0, 1'b1); ch_en = 2'b01;
    slots(5, 4); tick(4);
    chk("s1_n", 32'(log_addr.size()), 32'd3);
    chk("s1_a0", 32'(log_addr[0]), 32'h100);
    chk("s1_a1", 32'(log_addr[1]), 32'h101);
    chk("s1_a2", 32'(log_addr[2]), 32'h102);
    chk("s1_ch", 32'(log_ch[2]), 32'd0);
    chk("s1_stoff", 32'(stoff_n[0]), 32'd1);
    chk("s1_irq", 32'(irq_pend[0]), 32'd1);
    chk("s1_frame", 32'(sframe[0]), 32'd0);

    // repeat with a mid-frame change of bounds
    do_reset();
    set_ch(0, 22'h10, 22'h12, 1'b1, 1'b1); ch_en = 2'b01;
    slots(1, 2);
    set_ch(0, 22'h20, 22'h21, 1'b1, 1'b1);
    slots(9, 2); tick(3);
    chk("s2_a0", 32'(log_addr[0]), 32'h10);
    chk("s2_a1", 32'(log_addr[1]), 32'h11);
    chk("s2_a2", 32'(log_addr[2]), 32'h20);
    chk("s2_a3", 32'(log_addr[3]), 32'h20);
    chk("s2_stoff", 32'(stoff_n[0]), 32'd0);
    chk("s2_irq", 32'(irq_pend[0]), 32'd1);
    chk("s2_frame", 32'(sframe[0]), 32'd1);

    // round robin
    do_reset();
    set_ch(0, 22'h100, 22'h200, 1'b0, 1'b1);
    set_ch(1, 22'h300, 22'h400, 1'b0, 1'b1);
    ch_en = 2'b11; tick(2); clr_log();
    slots(4, 2); tick(3);
    chk("s3_n", 32'(log_ch.size()), 32'd4);
    chk("s3_c0", 32'(log_ch[0]), 32'd0);
    chk("s3_c1", 32'(log_ch[1]), 32'd1);
    chk("s3_c2", 32'(log_ch[2]), 32'd0);
    chk("s3_c3", 32'(log_ch[3]), 32'd1);
    chk("s3_a3", 32'(log_addr[3]), 32'h301);
    clr_log(); ch_sreq[1] = 1'b0;
    slots(3, 2); tick(3);
    chk("s3b_n", 32'(log_ch.size()), 32'd3);
    chk("s3b_c1", 32'(log_ch[1]), 32'd0);
    chk("s3b_c2", 32'(log_ch[2]), 32'd0);
    chk("s3b_a2", 32'(log_addr[2]), 32'h104);

    // empty frame
    do_reset();
    set_ch(0, 22'h40, 22'h40, 1'b0, 1'b1); ch_en = 2'b01;
    slots(4, 2); tick(3);
    chk("s4_n", 32'(log_addr.size()), 32'd0);
    chk("s4_stoff", 32'(stoff_n[0]), 32'd1);
    chk("s4_irq", 32'(irq_pend[0]), 32'd1);

    // address wrap
    do_reset();
    set_ch(0, 22'h3FFFFE, 22'h000001, 1'b0, 1'b1); ch_en = 2'b01;
    slots(6, 2); tick(3);
    chk("s4w_n", 32'(log_addr.size()), 32'd3);
    chk("s4w_a0", 32'(log_addr[0]), 32'h3FFFFE);
    chk("s4w_a1", 32'(log_addr[1]), 32'h3FFFFF);
    chk("s4w_a2", 32'(log_addr[2]), 32'h000000);

    // ack coincident with set; masking
    do_reset();
    set_ch(0, 22'h40, 22'h40, 1'b0, 1'b0); irq_mask = 2'b10; ch_en = 2'b01;
    tick(1); irq_ack = 2'b01; tick(1); irq_ack = 2'b00; tick(1);
    chk("s5_irq", 32'(irq_pend[0]), 32'd1);
    chk("s5_sint0", 32'(sint), 32'd0);
    irq_mask = 2'b11; #2;
    chk("s5_sint1", 32'(sint), 32'd1);
    irq_ack = 2'b01; tick(1); irq_ack = 2'b00;
    chk("s5_clr", 32'(irq_pend[0]), 32'd0);

    // ch_en drop coincident with slot
    do_reset();
    set_ch(0, 22'h100, 22'h200, 1'b0, 1'b1);
    set_ch(1, 22'h300, 22'h400, 1'b0, 1'b1);
    ch_en = 2'b11; tick(2);
    ch_en = 2'b10; bus.slot = 1'b1; tick(1); bus.slot = 1'b0; tick(3);
    chk("s6_n", 32'(log_ch.size()), 32'd1);
    chk("s6_ch", 32'(log_ch[0]), 32'd1);
    chk("s6_addr", 32'(log_addr[0]), 32'h300);
    chk("s6_frame", 32'(sframe[0]), 32'd0);
    chk("s6_irq", 32'(irq_pend), 32'd0);

    // reset coincident with slot, then restart on the first edge
    clr_log(); ch_en = 2'b11; tick(2);
    bus.slot = 1'b1; porb = 1'b0; tick(1); bus.slot = 1'b0; porb = 1'b1;
    chk("s6r_frame0", 32'(sframe), 32'd0);
    tick(1);
    chk("s6r_frame1", 32'(sframe), 32'h3);
    // reset while a grant is in flight
    bus.slot = 1'b1; tick(1); bus.slot = 1'b0; porb = 1'b0; tick(1); porb = 1'b1;
    tick(3);
    chk("s6r_n", 32'(log_ch.size()), 32'd0);
    chk("s6r_stoff", 32'(stoff_n[0] + stoff_n[1]), 32'd0);
    chk("s6r_irq", 32'(irq_pend), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/snd_dma_seq.md
SND_DMA_SEQ -- requirements
Module: snd_dma_seq

Interface
REQ-001 Parameter NCH, default 2: number of sound DMA channels, range 1..8.
REQ-002 Parameter AW, default 22: word-address counter width.
REQ-003 The clock and reset ports SHALL be listed first and SHALL be exactly: one clock, clk, with the reset asynchronous and active-low.
REQ-004 clk  input  1  block clock; all state changes on posedge.
REQ-005 porb  input  1  asynchronous active-low reset.
REQ-006 slot  input  1  DMA bus slot strobe, one clk wide, at most one grant per strobe.
REQ-007 ch_en  input  NCH  per-channel play enable (level).
REQ-008 ch_rep  input  NCH  per-channel repeat mode.
REQ-009 ch_start  input  NCH*AW  frame start address per channel; channel i uses bits [i*AW +: AW].
REQ-010 ch_end  input  NCH*AW  frame end address per channel, exclusive, same packing as ch_start.
REQ-011 ch_sreq  input  NCH  per-channel FIFO data request (level).
REQ-012 irq_mask  input  NCH  per-channel interrupt enable.
REQ-013 irq_ack  input  NCH  write-one-to-clear for irq_pend, one clk wide.
REQ-014 sload_n  output  1  active-low load strobe, one clk per granted word.
REQ-015 sload_ch  output  3  index of the granted channel, valid while sload_n=0.
REQ-016 dma_addr  output  AW  word address of the granted fetch, valid while sload_n=0.
REQ-017 sframe  output  NCH  channel is in RUN.
REQ-018 stoff  output  NCH  one-clk pulse when a non-repeat frame finishes.
REQ-019 irq_pend  output  NCH  frame-end pending flags.
REQ-020 sint  output  1  OR of (irq_pend & irq_mask).

Function
REQ-021 Each channel SHALL implement a two-state machine, IDLE and RUN, with an AW-bit counter cnt and latched registers sreg and ereg.
REQ-022 In IDLE with ch_en=1: on the next edge, sreg<=ch_start, ereg<=ch_end, cnt<=ch_start, and the state goes to RUN.
REQ-023 In any state with ch_en=0: on the next edge, the state goes to IDLE, with no stoff and no irq.
REQ-024 ch_start and ch_end SHALL be sampled only at frame start or reload; mid-frame changes take effect at the next frame.
REQ-025 A channel SHALL be eligible when it is in RUN, ch_sreq=1, ch_en=1, and cnt!=ereg.
REQ-026 On slot=1 with at least one channel eligible, the block SHALL grant one eligible channel by round-robin.
REQ-027 Round-robin search SHALL start at the channel after the last granted one; after reset it starts at channel 0.
REQ-028 Grant latency: slot at edge t gives sload_n=0, sload_ch and dma_addr=cnt (pre-increment) during the cycle after edge t+1, for exactly one clk.
REQ-029 On grant, cnt SHALL increment by 1 modulo 2^AW; wrap from all-ones to 0 is legal.
REQ-030 Frame end SHALL be detected when a RUN channel has cnt==ereg, including start==end at frame start.
REQ-031 Frame end with ch_rep=1: cnt<=ch_start, sreg<=ch_start and ereg<=ch_end are reloaded, the channel stays in RUN, and irq_pend[i] is set.
REQ-032 Frame end with ch_rep=0: the state goes to IDLE, stoff[i] pulses for 1 clk, and irq_pend[i] is set.
REQ-033 After a non-repeat frame end, a channel in IDLE SHALL restart only after ch_en falls and rises again.
REQ-034 Frame-end processing takes one clk, so no grant to that channel occurs in that cycle.
REQ-035 Simultaneous set and irq_ack on the same bit: set SHALL win.
REQ-036 ch_en falling in the same cycle as slot: that channel SHALL NOT be granted, and arbitration proceeds among the remaining eligible channels.
REQ-037 slot with no eligible channel: no strobe, and the round-robin pointer SHALL NOT change.
REQ-038 sint SHALL be combinational from registered irq_pend and irq_mask, with no extra latency.
REQ-039 sload_ch SHALL be zero-extended when NCH<8; sload_ch and dma_addr SHALL hold their last value when sload_n=1.

Reset
REQ-040 porb=0 SHALL asynchronously force: all channels IDLE, cnt/sreg/ereg=0, sload_n=1, sload_ch=0, dma_addr=0, sframe=0, stoff=0, irq_pend=0, round-robin pointer=0.
REQ-041 Reset asserted mid-frame or mid-strobe SHALL abort immediately, with no stoff or irq generated.
REQ-042 After porb rises, a channel with ch_en=1 SHALL start a frame on the next edge.

Verification
REQ-043 Single channel: NCH=2, ch0 start=0x100, end=0x103, rep=0, sreq=1, slot every 4 clk -> three strobes with addr 0x100, 0x101, 0x102, then stoff[0] pulses once, irq_pend[0]=1, sframe[0]=0.
REQ-044 Repeat and double buffer: start=0x10, end=0x12, rep=1; start changed to 0x20 and end to 0x21 during the frame -> addresses 0x10, 0x11, then 0x20, 0x20, ...; irq_pend set at each frame end; no stoff.
REQ-045 Round-robin: both channels eligible, slot every 2 clk -> sload_ch sequence 0, 1, 0, 1; with ch1 sreq=0 -> 0, 0, 0.
REQ-046 Boundaries: start=end=0x40 -> immediate frame end with no strobes. start=0x3FFFFE, end=0x000001 (AW=22) -> addresses 0x3FFFFE, 0x3FFFFF, 0x000000.
REQ-047 Interrupts: irq_ack[0] in the same cycle as the frame-end set -> irq_pend[0] stays 1. irq_mask[0]=0 -> sint=0 while irq_pend[0]=1.
REQ-048 Abort: ch_en or porb dropped mid-frame coincident with slot -> no strobe, sframe=0, no stoff, no irq.
